voice_mixer: RTL

Combines the per-voice oscillator samples into the single 8-bit `mixed_sample` consumed by the PWM output stage.
- Once per sample period, on a strobe, it snapshots all voices and sums the active ones serially.
- It divides the sum by the number of active voices with a multi-cycle restoring divider and registers the average.
- It sits directly upstream of the PWM stage and holds its output steady between updates.

---
 rtl/synth_pkg.sv | 14 +
 rtl/serial_divider.sv | 73 +++++++
 rtl/voice_mixer.sv | 133 +++++++++++++
 3 files changed

// File: rtl/synth_pkg.sv
// Shared types and constants for the synth voice path: sample width and the
// mixer state encoding (also used by benches to decode the debug state port).
package synth_pkg;

  localparam int SAMPLE_W = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCUM  = 2'd1,
    DIVIDE = 2'd2,
    LOAD   = 2'd3
  } mixer_state_t;

endpackage

// File: rtl/serial_divider.sv
// Unsigned restoring divider, one quotient bit per clock, DIVIDEND_W steps.
// The first step executes on the start edge, so the result is final after DIVIDEND_W edges.
module serial_divider #(
  parameter int DIVIDEND_W = 10,
  parameter int DIVISOR_W  = 3
) (
  input  logic                  clk,
  input  logic                  nrst,
  input  logic                  start,
  input  logic [DIVIDEND_W-1:0] dividend,
  input  logic [DIVISOR_W-1:0]  divisor,
  output logic [DIVIDEND_W-1:0] quotient,
  output logic                  done
);

  localparam int CNT_W = $clog2(DIVIDEND_W + 1);

  logic [DIVIDEND_W-1:0] r_quo;
  logic [DIVISOR_W-1:0]  r_rem;
  logic [DIVISOR_W-1:0]  r_div;
  logic                  r_zero;
  logic                  r_busy;
  logic [CNT_W-1:0]      r_cnt;

  logic [DIVIDEND_W-1:0] w_quo_in;
  logic [DIVISOR_W-1:0]  w_rem_in;
  logic [DIVISOR_W-1:0]  w_div_in;
  logic [DIVISOR_W:0]    w_trial;
  logic [DIVISOR_W:0]    w_diff;
  logic                  w_ge;
  logic [DIVISOR_W-1:0]  w_rem_next;

  // On start the step works straight from the inputs instead of the registers.
  assign w_quo_in   = start ? dividend : r_quo;
  assign w_rem_in   = start ? '0 : r_rem;
  assign w_div_in   = start ? divisor : r_div;
  assign w_trial    = {w_rem_in, w_quo_in[DIVIDEND_W-1]};
  assign w_ge       = (w_trial >= {1'b0, w_div_in});
  assign w_diff     = w_trial - {1'b0, w_div_in};
  assign w_rem_next = w_ge ? w_diff[DIVISOR_W-1:0] : w_trial[DIVISOR_W-1:0];

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_quo  <= '0;
      r_rem  <= '0;
      r_div  <= '0;
      r_zero <= 1'b0;
      r_busy <= 1'b0;
      r_cnt  <= '0;
    end else begin
      if (start) begin
        r_div  <= divisor;
        r_zero <= (divisor == '0);
        r_busy <= 1'b1;
        r_cnt  <= CNT_W'(DIVIDEND_W - 1);
      end else if (r_busy) begin
        r_cnt <= r_cnt - 1'b1;
        if (r_cnt == CNT_W'(1)) begin
          r_busy <= 1'b0;
        end
      end
      if (start || r_busy) begin
        r_quo <= {w_quo_in[DIVIDEND_W-2:0], w_ge};
        r_rem <= w_rem_next;
      end
    end
  end

  // done marks the cycle whose closing edge performs the final step.
  assign done     = r_busy && (r_cnt == CNT_W'(1));
  assign quotient = r_zero ? '0 : r_quo;

endmodule

// File: rtl/voice_mixer.sv
// Averages the active voice samples once per sample strobe: snapshot, serial sum,
// serial divide by the active count, then a registered clamped result for the PWM stage.
module voice_mixer #(
  parameter int NUM_VOICES = 4,
  parameter int SAMPLE_W   = synth_pkg::SAMPLE_W,
  parameter int ACC_W      = SAMPLE_W + $clog2(NUM_VOICES)
) (
  input  logic                           clk,
  input  logic                           nrst,
  input  logic                           enable,
  input  logic                           sample_strobe,
  input  logic [NUM_VOICES*SAMPLE_W-1:0] voice_samples,
  input  logic [NUM_VOICES-1:0]          voice_active,
  output logic [SAMPLE_W-1:0]            mixed_sample,
  output logic                           mix_valid,
  output logic                           busy,
  output logic                           overrun,
  output synth_pkg::mixer_state_t        dbg_state
);

  import synth_pkg::*;

  localparam int IDX_W = $clog2(NUM_VOICES);
  localparam int CNT_W = IDX_W + 1;

  // Handshake: sample_strobe is accepted only in IDLE; a strobe seen while busy is
  // dropped and flagged on overrun. mix_valid is a one-cycle pulse with no ready
  // back-pressure; mixed_sample holds its value until the next pulse.
  mixer_state_t                    r_state;
  logic [NUM_VOICES*SAMPLE_W-1:0]  r_samples;
  logic [NUM_VOICES-1:0]           r_active;
  logic [ACC_W-1:0]                r_acc;
  logic [CNT_W-1:0]                r_count;
  logic [IDX_W-1:0]                r_idx;
  logic                            r_div_first;
  logic [SAMPLE_W-1:0]             r_mixed;
  logic                            r_mix_valid;
  logic                            r_overrun;

  logic [SAMPLE_W-1:0]             w_sample;
  logic                            w_voice_on;
  logic                            w_last;
  logic                            w_div_start;
  logic                            w_div_done;
  logic [ACC_W-1:0]                w_quotient;
  logic [SAMPLE_W-1:0]             w_clamped;

  assign w_sample    = r_samples[r_idx*SAMPLE_W +: SAMPLE_W];
  assign w_voice_on  = r_active[r_idx];
  assign w_last      = (r_idx == IDX_W'(NUM_VOICES - 1));
  assign w_div_start = (r_state == DIVIDE) && r_div_first;
  assign w_clamped   = (|w_quotient[ACC_W-1:SAMPLE_W]) ? '1 : w_quotient[SAMPLE_W-1:0];

  serial_divider #(
    .DIVIDEND_W (ACC_W),
    .DIVISOR_W  (CNT_W)
  ) u_div (
    .clk      (clk),
    .nrst     (nrst),
    .start    (w_div_start),
    .dividend (r_acc),
    .divisor  (r_count),
    .quotient (w_quotient),
    .done     (w_div_done)
  );

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_state     <= IDLE;
      r_samples   <= '0;
      r_active    <= '0;
      r_acc       <= '0;
      r_count     <= '0;
      r_idx       <= '0;
      r_div_first <= 1'b0;
      r_mixed     <= '0;
      r_mix_valid <= 1'b0;
      r_overrun   <= 1'b0;
    end else if (!enable) begin
      // Disabled means silence, matching the PWM stage's idle output.
      r_state     <= IDLE;
      r_div_first <= 1'b0;
      r_mixed     <= '0;
      r_mix_valid <= 1'b0;
      r_overrun   <= 1'b0;
    end else begin
      r_mix_valid <= 1'b0;
      r_overrun   <= sample_strobe && (r_state != IDLE);
      case (r_state)
        IDLE: begin
          if (sample_strobe) begin
            r_samples <= voice_samples;
            r_active  <= voice_active;
            r_acc     <= '0;
            r_count   <= '0;
            r_idx     <= '0;
            r_state   <= ACCUM;
          end
        end
        ACCUM: begin
          if (w_voice_on) begin
            r_acc   <= r_acc + {{(ACC_W-SAMPLE_W){1'b0}}, w_sample};
            r_count <= r_count + 1'b1;
          end
          r_idx <= r_idx + 1'b1;
          if (w_last) begin
            r_div_first <= 1'b1;
            r_state     <= DIVIDE;
          end
        end
        DIVIDE: begin
          r_div_first <= 1'b0;
          if (!r_div_first && w_div_done) begin
            r_state <= LOAD;
          end
        end
        LOAD: begin
          r_mixed     <= w_clamped;
          r_mix_valid <= 1'b1;
          r_state     <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign mixed_sample = r_mixed;
  assign mix_valid    = r_mix_valid;
  assign busy         = (r_state != IDLE);
  assign overrun      = r_overrun;
  assign dbg_state    = r_state;

endmodule
